// File: rtl/fft_sched_pkg.sv
// Shared types and defaults for the radix-2 FFT butterfly scheduler.
package fft_sched_pkg;

  // Scheduler FSM states; internal to the scheduler, exported on no port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } sched_state_e;

  // Default butterfly datapath latency in cycles.
  localparam int DEF_COMPUTE_LAT = 3;

endpackage : fft_sched_pkg

// File: rtl/fft_bfly_addr.sv
// Combinational operand/twiddle address generator for one radix-2 butterfly.
// For stage s and butterfly b: half = 1<<s, pos = b mod half, grp = b / half,
// A = grp*2*half + pos, B = A + half, twiddle = pos << (LOG2N-1-s).
module fft_bfly_addr #(
  parameter int LOG2N = 4,
  parameter int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
  input  logic [SW-1:0]    stage_i,
  input  logic [LOG2N-2:0] bfly_i,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [LOG2N-2:0] tw_addr_o
);

  localparam int BW = LOG2N - 1;

  logic [LOG2N-1:0] half;
  logic [BW-1:0]    pos_mask;
  logic [BW-1:0]    pos;
  logic [BW-1:0]    grp;
  logic [LOG2N-1:0] addr_a;

  // Split the butterfly index into group and position within the group.
  always_comb begin
    half     = LOG2N'(1) << stage_i;
    pos_mask = ~({BW{1'b1}} << stage_i);
    pos      = bfly_i & pos_mask;
    grp      = bfly_i >> stage_i;
    addr_a   = ({1'b0, grp} << (int'(stage_i) + 1)) | {1'b0, pos};
  end

  assign addr_a_o  = addr_a;
  assign addr_b_o  = addr_a + half;
  assign tw_addr_o = pos << (LOG2N - 1 - int'(stage_i));

endmodule : fft_bfly_addr

// File: rtl/fft_bfly_sched.sv
// Butterfly scheduler: walks LOG2N stages x N/2 butterflies, issuing a read,
// waiting out the butterfly pipeline, then writing back in place.
module fft_bfly_sched
  import fft_sched_pkg::*;
#(
  parameter int N_POINTS    = 16,
  parameter int LOG2N       = $clog2(N_POINTS),
  parameter int COMPUTE_LAT = DEF_COMPUTE_LAT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     rd_gnt_i,
  input  logic                     wr_gnt_i,
  output logic                     rd_req_o,
  output logic                     wr_req_o,
  output logic [LOG2N-1:0]         addr_a_o,
  output logic [LOG2N-1:0]         addr_b_o,
  output logic [LOG2N-2:0]         tw_addr_o,
  output logic [$clog2(LOG2N)-1:0] stage_o,
  output logic                     end_compute_o,
  output logic                     end_algo_o,
  output logic                     done_o,
  output logic                     busy_o
);

  localparam int SW = $clog2(LOG2N);
  localparam int BW = LOG2N - 1;
  localparam int LW = (COMPUTE_LAT > 1) ? $clog2(COMPUTE_LAT) : 1;

  localparam logic [BW-1:0] BFLY_LAST  = BW'(N_POINTS / 2 - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2N - 1);
  localparam logic [LW-1:0] LAT_LOAD   = LW'(COMPUTE_LAT - 1);

  sched_state_e  state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [BW-1:0] bfly_q, bfly_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          end_algo;

  logic [LOG2N-1:0] raw_a, raw_b;
  logic [BW-1:0]    raw_tw;
  logic             in_bfly;

  // State and counter registers; reset aborts any run immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      stage_q <= '0;
      bfly_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state and counter update; grants only matter in their own state.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    bfly_d   = bfly_q;
    lat_d    = lat_q;
    end_algo = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          stage_d = '0;
          bfly_d  = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (rd_gnt_i) begin
          lat_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = WRITE;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      WRITE: begin
        if (wr_gnt_i) begin
          if (bfly_q != BFLY_LAST) begin
            bfly_d  = bfly_q + BW'(1);
            state_d = READ;
          end else begin
            bfly_d = '0;
            if (stage_q != STAGE_LAST) begin
              stage_d = stage_q + SW'(1);
              state_d = READ;
            end else begin
              end_algo = 1'b1;
              state_d  = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  fft_bfly_addr #(
    .LOG2N (LOG2N),
    .SW    (SW)
  ) u_addr (
    .stage_i   (stage_q),
    .bfly_i    (bfly_q),
    .addr_a_o  (raw_a),
    .addr_b_o  (raw_b),
    .tw_addr_o (raw_tw)
  );

  // Addresses are only meaningful while a butterfly is in flight; zero otherwise.
  assign in_bfly = (state_q == READ) || (state_q == WAIT) || (state_q == WRITE);

  assign addr_a_o      = in_bfly ? raw_a  : '0;
  assign addr_b_o      = in_bfly ? raw_b  : '0;
  assign tw_addr_o     = in_bfly ? raw_tw : '0;
  assign stage_o       = stage_q;
  assign rd_req_o      = (state_q == READ);
  assign wr_req_o      = (state_q == WRITE);
  assign end_compute_o = (state_q == WAIT) && (lat_q == '0);
  assign end_algo_o    = end_algo;
  assign done_o        = (state_q == DONE);
  assign busy_o        = (state_q != IDLE);

endmodule : fft_bfly_sched

// File: tb/tb_fft_bfly_sched.sv
// Self-checking bench for fft_bfly_sched (N=16, COMPUTE_LAT=3).
// A reference schedule built from group/position arithmetic is compared
// against every read and write handshake; run lengths are checked against
// butterflies*(2+LAT) plus the observed stall cycles.
module tb_fft_bfly_sched;

  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int LAT   = 3;
  localparam int NBF   = (N / 2) * LOG2N;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       rd_gnt_i = 1'b0;
  logic       wr_gnt_i = 1'b0;
  logic       rd_req_o, wr_req_o;
  logic [3:0] addr_a_o, addr_b_o;
  logic [2:0] tw_addr_o;
  logic [1:0] stage_o;
  logic       end_compute_o, end_algo_o, done_o, busy_o;

  int checks = 0;
  int failures = 0;

  // Reference schedule, in issue order.
  int exp_s [NBF];
  int exp_a [NBF];
  int exp_b [NBF];
  int exp_tw[NBF];

  // Run control written only by the main process.
  int run_id = 0;
  bit grant_rnd = 1'b0;
  bit hold_rd = 1'b0;
  bit hold_wr = 1'b0;

  // Monitor state written only by the monitor process.
  int mon_run = 0;
  int idx, stalls, cyc, first_rd, done_cyc, ec_cnt, ea_cnt, dn_cnt;
  bit rd_wait_prev, wr_wait_prev, exp_idle, exp_rd;
  logic [3:0] sv_a, sv_b;
  logic [2:0] sv_tw;
  int touched[LOG2N][N];

  // Grant driver state.
  int drv_run = 0;
  int rd_hold_left, wr_hold_left, wr_seen;

  fft_bfly_sched #(
    .N_POINTS    (N),
    .COMPUTE_LAT (LAT)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .rd_gnt_i      (rd_gnt_i),
    .wr_gnt_i      (wr_gnt_i),
    .rd_req_o      (rd_req_o),
    .wr_req_o      (wr_req_o),
    .addr_a_o      (addr_a_o),
    .addr_b_o      (addr_b_o),
    .tw_addr_o     (tw_addr_o),
    .stage_o       (stage_o),
    .end_compute_o (end_compute_o),
    .end_algo_o    (end_algo_o),
    .done_o        (done_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Build the schedule from groups of 2*half points, butterflies ordered by index.
  initial begin
    int k;
    for (int s = 0; s < LOG2N; s++) begin
      int half;
      half = 1 << s;
      for (int g = 0; g < (N / 2) / half; g++) begin
        for (int p = 0; p < half; p++) begin
          k = s * (N / 2) + g * half + p;
          exp_s[k]  = s;
          exp_a[k]  = g * 2 * half + p;
          exp_b[k]  = g * 2 * half + p + half;
          exp_tw[k] = p * ((N / 2) / half);
        end
      end
    end
  end

  // Grant driver: tied high, random, or held low for 4 cycles on demand.
  always @(posedge clk_i) begin
    #1;
    if (drv_run != run_id) begin
      drv_run      = run_id;
      rd_hold_left = hold_rd ? 4 : 0;
      wr_hold_left = hold_wr ? 4 : 0;
      wr_seen      = 0;
    end
    if (rd_req_o && rd_hold_left > 0) begin
      rd_gnt_i = 1'b0;
      rd_hold_left--;
    end else begin
      rd_gnt_i = grant_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    if (wr_req_o && wr_hold_left > 0 && wr_seen >= 2) begin
      wr_gnt_i = 1'b0;
      wr_hold_left--;
    end else begin
      wr_gnt_i = grant_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    if (wr_req_o && wr_gnt_i) wr_seen++;
  end

  // Monitor: checks every handshake against the reference schedule.
  always @(negedge clk_i) begin
    if (mon_run != run_id) begin
      mon_run  = run_id;
      idx = 0; stalls = 0; cyc = 0; first_rd = -1; done_cyc = -1;
      ec_cnt = 0; ea_cnt = 0; dn_cnt = 0;
      rd_wait_prev = 0; wr_wait_prev = 0; exp_idle = 0; exp_rd = 0;
      for (int s = 0; s < LOG2N; s++)
        for (int a = 0; a < N; a++) touched[s][a] = 0;
    end
    if (!rst_ni) begin
      rd_wait_prev = 0; wr_wait_prev = 0; exp_idle = 0; exp_rd = 0;
    end else begin
      cyc++;
      if (exp_idle) chk("wait_after_rd_gnt", {30'd0, rd_req_o, wr_req_o}, 0);
      if (exp_rd) chk("read_after_wr_gnt", rd_req_o, 1);
      exp_idle = 0;
      exp_rd   = 0;
      if (rd_wait_prev) begin
        chk("rd_req_held", rd_req_o, 1);
        chk("rd_addr_stable", {addr_a_o, addr_b_o, tw_addr_o}, {sv_a, sv_b, sv_tw});
      end
      if (wr_wait_prev) begin
        chk("wr_req_held", wr_req_o, 1);
        chk("wr_addr_stable", {addr_a_o, addr_b_o, tw_addr_o}, {sv_a, sv_b, sv_tw});
      end
      rd_wait_prev = 0;
      wr_wait_prev = 0;
      chk("req_exclusive", rd_req_o & wr_req_o, 0);
      if (rd_req_o) begin
        if (first_rd < 0) first_rd = cyc;
        if (rd_gnt_i) begin
          chk("rd_idx_in_range", idx < NBF, 1);
          if (idx < NBF) begin
            chk("rd_stage", stage_o, exp_s[idx]);
            chk("rd_addr_a", addr_a_o, exp_a[idx]);
            chk("rd_addr_b", addr_b_o, exp_b[idx]);
            chk("rd_tw", tw_addr_o, exp_tw[idx]);
            touched[stage_o][addr_a_o]++;
            touched[stage_o][addr_b_o]++;
          end
          exp_idle = 1;
        end else begin
          stalls++;
          rd_wait_prev = 1;
          sv_a = addr_a_o; sv_b = addr_b_o; sv_tw = tw_addr_o;
        end
      end
      if (wr_req_o) begin
        if (wr_gnt_i) begin
          chk("wr_idx_in_range", idx < NBF, 1);
          if (idx < NBF) begin
            chk("wr_stage", stage_o, exp_s[idx]);
            chk("wr_addr_a", addr_a_o, exp_a[idx]);
            chk("wr_addr_b", addr_b_o, exp_b[idx]);
            chk("wr_end_algo", end_algo_o, idx == NBF - 1);
            $display("xfer run=%0d idx=%0d s=%0d a=%0d b=%0d tw=%0d",
                     run_id, idx, stage_o, addr_a_o, addr_b_o, tw_addr_o);
          end
          idx++;
          if (idx < NBF) exp_rd = 1;
        end else begin
          stalls++;
          wr_wait_prev = 1;
          sv_a = addr_a_o; sv_b = addr_b_o; sv_tw = tw_addr_o;
        end
      end
      if (end_compute_o) ec_cnt++;
      if (end_algo_o) ea_cnt++;
      if (done_o) begin
        dn_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
  endtask

  // One complete run followed by end-of-run checks.
  task automatic do_run(input bit rnd, input bit hrd, input bit hwr, input bit mid_start,
                        input int exp_stalls);
    bit seen;
    int bad;
    grant_rnd = rnd;
    hold_rd   = hrd;
    hold_wr   = hwr;
    run_id++;
    pulse_start();
    if (mid_start) begin
      repeat (37) @(posedge clk_i);
      #1 start_i = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk_i);
      if (dn_cnt > 0) seen = 1;
    end
    chk("done_within_budget", seen, 1);
    repeat (2) @(posedge clk_i);
    #1;
    chk("done_pulses", dn_cnt, 1);
    chk("end_algo_pulses", ea_cnt, 1);
    chk("end_compute_pulses", ec_cnt, NBF);
    chk("butterflies_written", idx, NBF);
    chk("run_cycles", done_cyc - first_rd, NBF * (2 + LAT) + stalls);
    if (exp_stalls >= 0) chk("stall_cycles", stalls, exp_stalls);
    chk("idle_after_done", busy_o, 0);
    bad = 0;
    for (int s = 0; s < LOG2N; s++)
      for (int a = 0; a < N; a++)
        if (touched[s][a] != 1) bad++;
    chk("addr_once_per_stage", bad, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {busy_o, rd_req_o, wr_req_o, addr_a_o, addr_b_o, tw_addr_o, stage_o,
              end_compute_o, end_algo_o, done_o}, 0);
  endtask

  initial begin
    bit found;
    #1;
    chk_outputs_zero("reset_outputs");
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk_outputs_zero("idle_outputs");

    // Grants tied high: exactly 160 cycles from first READ to DONE.
    do_run(1'b0, 1'b0, 1'b0, 1'b0, 0);
    // 4-cycle read hold and 4-cycle write hold.
    do_run(1'b0, 1'b1, 1'b1, 1'b0, 8);
    // Mid-run start pulse with grants tied high must not perturb the run.
    do_run(1'b0, 1'b0, 1'b0, 1'b1, 0);
    // Randomised grants, with and without a stray start.
    do_run(1'b1, 1'b0, 1'b0, 1'b1, -1);
    do_run(1'b1, 1'b0, 1'b0, 1'b0, -1);

    // Asynchronous reset during a stage-2 WAIT cycle.
    grant_rnd = 1'b1;
    hold_rd   = 1'b0;
    hold_wr   = 1'b0;
    run_id++;
    pulse_start();
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk_i);
      if (stage_o == 2'd2 && busy_o && !rd_req_o && !wr_req_o && !done_o) found = 1;
    end
    chk("reached_stage2_wait", found, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk_outputs_zero("async_reset_outputs");
    repeat (2) @(posedge clk_i);
    #1;
    chk_outputs_zero("held_reset_outputs");
    rst_ni = 1'b1;

    // Fresh run after the abort restarts at stage 0, butterfly 0.
    do_run(1'b1, 1'b0, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fft_bfly_sched
